// File: rtl/svf_pkg.sv
// rtl/svf_pkg.sv - shared types, constants and saturation helper for the multichannel SVF
package svf_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = DATA_W + 2;
  // Headroom for intermediate sums before they are clamped back to ACC_W or DATA_W
  localparam int WIDE_W = 40;

  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t S_FBP   = 3'd1;
  localparam state_t S_QBP   = 3'd2;
  localparam state_t S_FHP   = 3'd3;
  localparam state_t S_STORE = 3'd4;

  typedef enum logic [1:0] {
    HP    = 2'd0,
    LP    = 2'd1,
    BP    = 2'd2,
    NOTCH = 2'd3
  } mode_t;

  function automatic logic signed [WIDE_W-1:0] sat(input logic signed [WIDE_W-1:0] value,
                                                   input int width);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (WIDE_W'(1) <<< (width - 1)) - WIDE_W'(1);
    lo = -hi - WIDE_W'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/svf_mul.sv
// rtl/svf_mul.sv - registered signed x unsigned multiply, Q1.(W-1) rescale and clamp to W+2 bits
module svf_mul
  import svf_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W+1:0] a,
  input  logic        [W-1:0] b,
  output logic signed [W+1:0] p
);

  localparam int PW = 2 * W + 3;

  logic signed [PW-1:0] full;

  always_comb begin
    full = PW'(a) * PW'($signed({1'b0, b}));
  end

  // Arithmetic shift floors toward minus infinity, matching the loop's truncation behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= (W + 2)'(sat(WIDE_W'(full >>> (W - 1)), W + 2));
    end
  end

endmodule

// File: rtl/svf_multichannel.sv
// rtl/svf_multichannel.sv - N-channel time-multiplexed Chamberlin state-variable filter
// One shared multiplier; four cycles per channel per sample_clk rising edge.
module svf_multichannel
  import svf_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int CH    = 4,
  parameter int Q_MIN = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample_clk,
  input  logic [CH*W-1:0] sample_in,
  input  logic [CH*W-1:0] cutoff,
  input  logic [CH*W-1:0] resonance,
  input  logic [CH*2-1:0] mode,
  output logic [CH*W-1:0] sample_out,
  output logic            out_valid,
  output logic            busy,
  output logic            overrun
);

  localparam int AW = W + 2;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [W-1:0] MID    = {1'b1, {(W - 1){1'b0}}};
  localparam logic [W-1:0] QMIN_V = W'(Q_MIN);

  logic [2:0] sync_q;
  logic       samp_rise;

  logic signed [W-1:0] snap_in   [CH];
  logic        [W-1:0] snap_cut  [CH];
  logic        [W-1:0] snap_res  [CH];
  logic        [1:0]   snap_mode [CH];

  state_t         state;
  logic [CW-1:0]  ch;

  logic signed [AW-1:0] lp_mem [CH];
  logic signed [AW-1:0] bp_mem [CH];
  logic signed [AW-1:0] lp_new;
  logic signed [AW-1:0] hp_reg;
  logic signed [AW-1:0] prod;
  logic        [W-1:0]  out_reg [CH];

  logic        [W-1:0]  u_cut;
  logic        [W-1:0]  u_res;
  logic        [W-1:0]  f_coef;
  logic        [W-1:0]  q_raw;
  logic        [W-1:0]  q_coef;
  logic signed [AW-1:0] mul_a;
  logic        [W-1:0]  mul_b;
  logic signed [AW-1:0] lp_sum;
  logic signed [AW-1:0] hp_next;
  logic signed [AW-1:0] bp_sum;
  logic signed [AW-1:0] notch_sum;
  logic signed [AW-1:0] sel;
  logic        [W-1:0]  out_w;
  mode_t                cur_mode;

  // Two synchroniser flops plus one history flop for the rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sample_clk};
    end
  end

  assign samp_rise = sync_q[1] & ~sync_q[2];
  assign busy      = (state != IDLE);

  always_comb begin
    u_cut  = snap_cut[ch] ^ MID;
    u_res  = snap_res[ch] ^ MID;
    f_coef = u_cut >> 2;
    q_raw  = MID - (u_res >> 1);
    q_coef = (q_raw < QMIN_V) ? QMIN_V : q_raw;
  end

  always_comb begin
    lp_sum    = AW'(sat(WIDE_W'(lp_mem[ch]) + WIDE_W'(prod), AW));
    hp_next   = AW'(sat(WIDE_W'(snap_in[ch]) - WIDE_W'(lp_new) - WIDE_W'(prod), AW));
    bp_sum    = AW'(sat(WIDE_W'(bp_mem[ch]) + WIDE_W'(prod), AW));
    notch_sum = AW'(sat(WIDE_W'(hp_reg) + WIDE_W'(lp_new), AW));
  end

  // hp feeds the multiplier combinationally so f*hp is ready in S_STORE
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_FBP: begin
        mul_a = bp_mem[ch];
        mul_b = f_coef;
      end
      S_QBP: begin
        mul_a = bp_mem[ch];
        mul_b = q_coef;
      end
      S_FHP: begin
        mul_a = hp_next;
        mul_b = f_coef;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  always_comb begin
    cur_mode = mode_t'(snap_mode[ch]);
    sel      = notch_sum;
    case (cur_mode)
      HP:      sel = hp_reg;
      LP:      sel = lp_new;
      BP:      sel = bp_sum;
      default: sel = notch_sum;
    endcase
    out_w = W'(sat(WIDE_W'(sel), W));
  end

  svf_mul #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mul_a),
    .b     (mul_b),
    .p     (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      lp_new    <= '0;
      hp_reg    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        snap_in[c]   <= '0;
        snap_cut[c]  <= '0;
        snap_res[c]  <= '0;
        snap_mode[c] <= '0;
        lp_mem[c]    <= '0;
        bp_mem[c]    <= '0;
        out_reg[c]   <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= samp_rise && (state != IDLE);
      case (state)
        IDLE: begin
          if (samp_rise) begin
            for (int c = 0; c < CH; c++) begin
              snap_in[c]   <= sample_in[c*W +: W];
              snap_cut[c]  <= cutoff[c*W +: W];
              snap_res[c]  <= resonance[c*W +: W];
              snap_mode[c] <= mode[c*2 +: 2];
            end
            ch    <= '0;
            state <= S_FBP;
          end
        end
        S_FBP: begin
          state <= S_QBP;
        end
        S_QBP: begin
          lp_new <= lp_sum;
          state  <= S_FHP;
        end
        S_FHP: begin
          hp_reg <= hp_next;
          state  <= S_STORE;
        end
        S_STORE: begin
          lp_mem[ch]  <= lp_new;
          bp_mem[ch]  <= bp_sum;
          out_reg[ch] <= out_w;
          if (ch == CW'(CH - 1)) begin
            out_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            ch    <= ch + CW'(1);
            state <= S_FBP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign sample_out[g*W +: W] = out_reg[g];
  end

endmodule

// File: tb/tb_svf_multichannel.sv
// tb/tb_svf_multichannel.sv - scoreboard bench for svf_multichannel against an integer SVF model
module tb_svf_multichannel;

  localparam int W  = 16;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sample_clk;
  logic [CH*W-1:0] sample_in;
  logic [CH*W-1:0] cutoff;
  logic [CH*W-1:0] resonance;
  logic [CH*2-1:0] mode;
  logic [CH*W-1:0] sample_out;
  logic            out_valid;
  logic            busy;
  logic            overrun;

  int checks = 0;
  int fails  = 0;
  int ovr_cnt = 0;
  int busy_cnt = 0;
  logic prev_busy = 1'b0;

  logic [CH*W-1:0] exp_q[$];
  longint m_lp[CH];
  longint m_bp[CH];

  svf_multichannel #(.W(W), .CH(CH), .Q_MIN(4096)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_clk (sample_clk),
    .sample_in  (sample_in),
    .cutoff     (cutoff),
    .resonance  (resonance),
    .mode       (mode),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint v, input int width);
    longint hi;
    hi = (longint'(1) << (width - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic longint floor_div(input longint v, input longint d);
    longint q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint fmul(input longint x, input longint coef);
    return clamp(floor_div(x * coef, 32768), 18);
  endfunction

  // Chamberlin step per channel: lp += f*bp; hp = x - lp - q*bp; bp += f*hp
  function automatic logic [CH*W-1:0] model_run(input logic [CH*W-1:0] xin,
                                                input logic [CH*W-1:0] cut,
                                                input logic [CH*W-1:0] res,
                                                input logic [CH*2-1:0] md);
    logic [CH*W-1:0] e;
    logic [15:0] s16;
    logic [1:0] m2;
    longint x, f, q, lpn, hp, bpn, notch, o;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      s16 = xin[c*W +: W];
      x = longint'($signed(s16));
      s16 = cut[c*W +: W];
      f = (longint'($signed(s16)) + 32768) / 4;
      s16 = res[c*W +: W];
      q = 32768 - (longint'($signed(s16)) + 32768) / 2;
      if (q < 4096) q = 4096;
      lpn   = clamp(m_lp[c] + fmul(m_bp[c], f), 18);
      hp    = clamp(x - lpn - fmul(m_bp[c], q), 18);
      bpn   = clamp(m_bp[c] + fmul(hp, f), 18);
      notch = clamp(hp + lpn, 18);
      m2 = md[c*2 +: 2];
      case (m2)
        2'd0:    o = hp;
        2'd1:    o = lpn;
        2'd2:    o = bpn;
        default: o = notch;
      endcase
      m_lp[c] = lpn;
      m_bp[c] = bpn;
      e[c*W +: W] = 16'(clamp(o, 16));
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on out_valid and checks busy width at its falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          logic [CH*W-1:0] e;
          logic [15:0] g16, e16;
          e = exp_q.pop_front();
          for (int c = 0; c < CH; c++) begin
            g16 = sample_out[c*W +: W];
            e16 = e[c*W +: W];
            check($sformatf("out_ch%0d", c), longint'($signed(g16)), longint'($signed(e16)));
          end
        end
      end
      if (prev_busy && !busy) begin
        check("busy_width", busy_cnt, 16);
        check("out_valid_on_busy_fall", out_valid, 1);
      end
      if (overrun) ovr_cnt++;
      busy_cnt  = busy ? busy_cnt + 1 : 0;
      prev_busy = busy;
    end else begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end
  end

  task automatic clear_model();
    exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      m_lp[c] = 0;
      m_bp[c] = 0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    sample_clk = 1'b0;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_sample(input logic [CH*W-1:0] xin, input logic [CH*W-1:0] cut,
                              input logic [CH*W-1:0] res, input logic [CH*2-1:0] md);
    int n;
    repeat (3) @(posedge clk);
    #1;
    sample_in  = xin;
    cutoff     = cut;
    resonance  = res;
    mode       = md;
    sample_clk = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 10);
    check("busy_start", busy, 1);
    if (busy) exp_q.push_back(model_run(xin, cut, res, md));
  endtask

  task automatic finish_sample();
    int n;
    @(posedge clk);
    #1;
    sample_clk = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_end", busy, 0);
  endtask

  task automatic run_sample(input logic [CH*W-1:0] xin, input logic [CH*W-1:0] cut,
                            input logic [CH*W-1:0] res, input logic [CH*2-1:0] md);
    start_sample(xin, cut, res, md);
    finish_sample();
  endtask

  function automatic logic [CH*W-1:0] rnd_vec();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] g16;
    int ovr_before;
    longint v;
    rst_n      = 1'b0;
    sample_clk = 1'b0;
    sample_in  = '0;
    cutoff     = '0;
    resonance  = '0;
    mode       = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_out", longint'(sample_out != 0), 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    for (int s = 0; s < 40; s++) begin
      run_sample(rnd_vec(), rnd_vec(), rnd_vec(), 8'($urandom()));
    end

    ovr_before = ovr_cnt;
    start_sample(rnd_vec(), rnd_vec(), rnd_vec(), 8'($urandom()));
    @(posedge clk);
    #1 sample_clk = 1'b0;
    @(posedge clk);
    #1 sample_clk = 1'b1;
    finish_sample();
    repeat (3) @(negedge clk);
    check("overrun_pulse", ovr_cnt - ovr_before, 1);
    check("overrun_no_restart", exp_q.size(), 0);
    run_sample(rnd_vec(), rnd_vec(), rnd_vec(), 8'($urandom()));

    start_sample(rnd_vec(), rnd_vec(), rnd_vec(), 8'($urandom()));
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sample_clk = 1'b0;
    clear_model();
    #1;
    check("abort_sample_out", longint'(sample_out != 0), 0);
    check("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run_sample(rnd_vec(), rnd_vec(), rnd_vec(), 8'($urandom()));

    apply_reset();
    for (int s = 0; s < 5; s++) begin
      run_sample({4{16'd1000}}, {4{16'h8000}}, rnd_vec(), 8'b11_10_01_00);
      g16 = sample_out[15:0];
      check("fzero_hp", longint'($signed(g16)), 1000);
      g16 = sample_out[31:16];
      check("fzero_lp", longint'($signed(g16)), 0);
    end

    apply_reset();
    for (int s = 0; s < 300; s++) begin
      run_sample({4{16'd8000}}, '0, {4{16'h8000}}, 8'b11_10_01_00);
    end

    apply_reset();
    for (int s = 0; s < 40; s++) begin
      v = ((s / 4) % 2 == 0) ? 32767 : -32767;
      run_sample({48'd0, 16'(v)}, {4{16'h7fff}}, {4{16'h7fff}}, 8'(s % 4));
      for (int c = 1; c < CH; c++) begin
        g16 = sample_out[c*W +: W];
        check($sformatf("zero_ch%0d", c), longint'($signed(g16)), 0);
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("overrun_total", ovr_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
